// File: rtl/riscv_soft_imm_encoder_pkg.sv
// Shared types and helpers for the immediate encoder: format codes,
// buffer entry layout and the sign-representability check.
package riscv_soft_imm_encoder_pkg;

    localparam int XPR_LEN = 32;

    // Immediate format selector codes, same encoding as the decode path.
    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_U = 3'd3,
        IMM_J = 3'd4
    } imm_sel_e;

    // One buffered result: packed instruction plus its error flag.
    typedef struct packed {
        logic [31:0] inst;
        logic        err;
    } enc_entry_t;

    // True when bits [31:msb] of v are all copies of the sign bit, i.e. the
    // value survives truncation to an (msb+1)-bit signed field.
    function automatic logic fits_signed(input logic [XPR_LEN-1:0] v,
                                         input int unsigned        msb);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < XPR_LEN; i++) begin
            if (i >= int'(msb) && v[i] != v[XPR_LEN-1]) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

endpackage

// File: rtl/riscv_soft_imm_pack.sv
// Combinational immediate packer: scatters imm into the I/S/B/U/J bit
// positions of base_inst and flags immediates the format cannot hold.
module riscv_soft_imm_pack
    import riscv_soft_imm_encoder_pkg::*;
(
    input  logic [2:0]         imm_sel,
    input  logic [XPR_LEN-1:0] imm,
    input  logic [31:0]        base_inst,
    output logic [31:0]        inst,
    output logic               err
);

    // Overwrite only the immediate fields of the selected format.
    always_comb begin
        // NOTE: every output gets a default first so no path through the case leaves a latch.
        inst = base_inst;
        err  = 1'b0;
        case (imm_sel_e'(imm_sel))
            IMM_I: begin
                inst[31:20] = imm[11:0];
                err         = !fits_signed(imm, 11);
            end
            IMM_S: begin
                inst[31:25] = imm[11:5];
                inst[11:7]  = imm[4:0];
                err         = !fits_signed(imm, 11);
            end
            IMM_B: begin
                inst[31]    = imm[12];
                inst[30:25] = imm[10:5];
                inst[11:8]  = imm[4:1];
                inst[7]     = imm[11];
                err         = imm[0] || !fits_signed(imm, 12);
            end
            IMM_U: begin
                inst[31:12] = imm[31:12];
                err         = |imm[11:0];
            end
            IMM_J: begin
                inst[31]    = imm[20];
                inst[30:21] = imm[10:1];
                inst[20]    = imm[11];
                inst[19:12] = imm[19:12];
                err         = imm[0] || !fits_signed(imm, 20);
            end
            default: begin
                err = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/riscv_soft_imm_encoder.sv
// Immediate encoder top: packs requests through riscv_soft_imm_pack into a
// 2-entry FIFO with valid/ready on both sides and a saturating error count.
module riscv_soft_imm_encoder
    import riscv_soft_imm_encoder_pkg::*;
#(
    parameter int XPR_LEN   = 32,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           in_imm_sel,
    input  logic [XPR_LEN-1:0]   in_imm,
    input  logic [31:0]          in_base_inst,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_inst,
    output logic                 out_err,
    output logic [ERR_CNT_W-1:0] err_count
);

    enc_entry_t pack_entry;
    enc_entry_t mem [2];
    logic       wr_ptr;
    logic       rd_ptr;
    logic [1:0] count;
    logic       live;
    logic       push;
    logic       pop;

    riscv_soft_imm_pack u_pack (
        .imm_sel   (in_imm_sel),
        .imm       (in_imm),
        .base_inst (in_base_inst),
        .inst      (pack_entry.inst),
        .err       (pack_entry.err)
    );

    // Ready depends only on registered state, never on out_ready.
    assign in_ready  = live && (count < 2'd2);
    assign out_valid = (count != 2'd0);
    assign out_inst  = mem[rd_ptr].inst;
    assign out_err   = mem[rd_ptr].err;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // FIFO storage, pointers, occupancy and the error counter.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            // NOTE: the two entries are reset so out_inst/out_err read zero out of reset.
            for (int i = 0; i < 2; i++) begin
                mem[i] <= '0;
            end
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            count     <= 2'd0;
            live      <= 1'b0;
            err_count <= '0;
        end else begin
            // NOTE: state is updated with non-blocking assignments so all flops see pre-edge values.
            live <= 1'b1;
            if (push) begin
                mem[wr_ptr] <= pack_entry;
                wr_ptr      <= ~wr_ptr;
                if (pack_entry.err && (err_count != '1)) begin
                    err_count <= err_count + 1'b1;
                end
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: doc/riscv_soft_imm_encoder.md
Name: riscv_soft_imm_encoder

Overview:
Inverse of the immediate decode path: packs an XPR_LEN-bit immediate into the RISC-V I/S/B/U/J bit positions of a 32-bit instruction word.
- Input is a base instruction; its non-immediate fields (opcode/rd/rs1/rs2/funct) are preserved, immediate bit positions overwritten.
- Also checks that the immediate is representable in the selected format.
- Used by the self-test/trace-replay instruction generator and the debug instruction injector.
- Valid/ready on both sides; 2-entry output buffer.

Parameters:
XPR_LEN, 32, datapath width of imm (32 only for this revision)
ERR_CNT_W, 8, width of saturating error counter

Ports:
clk  input  1  clock, all state on rising edge
reset_n  input  1  synchronous, active-low reset
in_valid  input  1  request valid
in_ready  output  1  buffer can accept
in_imm_sel  input  3  format code, `IMM_I/`IMM_S/`IMM_B/`IMM_U/`IMM_J
in_imm  input  XPR_LEN  immediate value (two's complement)
in_base_inst  input  32  instruction with non-immediate fields set
out_valid  output  1  head entry valid
out_ready  input  1  consumer accepts head
out_inst  output  32  packed instruction
out_err  output  1  immediate not representable / bad imm_sel
err_count  output  ERR_CNT_W  saturating count of accepted requests with err=1

Behaviour:
- Reset, synchronous on clk while reset_n=0:
  - count=0, out_valid=0, in_ready=0 during reset, out_inst=0, out_err=0, err_count=0.
  - Reset mid-operation discards buffered entries.
- Accept on in_valid&in_ready; pop on out_valid&out_ready.
- in_ready = (count<2), registered-only dependency; no combinational path from out_ready to in_ready.
- Latency: request accepted at edge N appears on out_* after edge N if the buffer was empty, i.e. out_valid high in cycle N+1.
- Ordering strictly FIFO. Push and pop in the same cycle at count=1: count stays 1, new entry becomes head next cycle.
- count=2: in_ready=0; pop frees a slot visible the following cycle.
- out_inst/out_err hold stable while out_valid&!out_ready.
- Packing (bits not listed come from in_base_inst):
  - I: inst[31:20]=imm[11:0]; legal iff imm[31:11] all equal.
  - S: inst[31:25]=imm[11:5], inst[11:7]=imm[4:0]; legal as I.
  - B: inst[31]=imm[12], inst[30:25]=imm[10:5], inst[11:8]=imm[4:1], inst[7]=imm[11]; legal iff imm[0]=0 and imm[31:12] all equal.
  - U: inst[31:12]=imm[31:12]; legal iff imm[11:0]=0.
  - J: inst[31]=imm[20], inst[30:21]=imm[10:1], inst[20]=imm[11], inst[19:12]=imm[19:12]; legal iff imm[0]=0 and imm[31:20] all equal.
  - Other sel: inst=in_base_inst, err=1.
- Illegal immediates are still packed (truncated bits dropped); err=1.
- err_count increments on each accepted request with err=1 and saturates at all-ones.

Decomposition:
- Format codes (`IMM_I..`IMM_J) and XPR_LEN stay in riscv_soft_constants.v; no new constants.
- One combinational sub-module, riscv_soft_imm_pack (imm_sel, imm, base_inst -> inst, err).
- Top holds the 2-entry buffer, count and err_count.

Test Plan:
- I, imm=0xFFFFFFFF, base=0x00000013 -> out_inst=0xFFF00013, err=0, out_valid one cycle after accept.
- I, imm=0x00000800, base=0x00000013 -> out_inst=0x80000013, err=1, err_count 0->1.
- B, imm=0xFFFFFFFC, base=0x00000063 -> 0xFE000EE3, err=0; B imm=0x00000002 gives err=0; imm=0x00000001 gives err=1.
- U imm=0x12345000 base=0x00000037 -> 0x12345037 err=0; J imm=0x00000800 base=0x0000006F -> 0x0010006F err=0; sel=3'b111 -> base unchanged, err=1.
- out_ready=0, push 3 back-to-back -> 2 accepted, in_ready=0 from cycle after second accept. Raise out_ready -> entries drain in order, outputs stable while stalled. Then push+pop at count=1 keeps count=1.
- Fill buffer, assert reset_n=0 one cycle -> out_valid=0, err_count=0, in_ready=1 after release. Also drive 300 err requests -> err_count saturates at 0xFF.
